// File: rtl/alu_arbiter.sv
// Round-robin / fixed-priority arbiter sharing one ALU between two requesters.
// One op in flight; operands latched on accept, result and flags registered.
module alu_arbiter #(
    parameter int WIDTH       = 32,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [3:0]       r0_op,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    output logic             r0_rsp_valid,
    input  logic             r0_rsp_ready,
    output logic [WIDTH-1:0] r0_result,
    output logic [3:0]       r0_flags,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [3:0]       r1_op,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    output logic             r1_rsp_valid,
    input  logic             r1_rsp_ready,
    output logic [WIDTH-1:0] r1_result,
    output logic [3:0]       r1_flags,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_src_a,
    output logic [WIDTH-1:0] alu_src_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic             alu_negative,
    input  logic             alu_carry,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t           state;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [3:0]       flg_q;
    logic             owner_q;
    logic             last_q;
    logic             gnt;
    logic             idle;
    logic             accept;
    logic             rsp_fire;

    always_comb begin
        gnt = 1'b0;
        unique case (1'b1)
            r0_valid && r1_valid:  gnt = ROUND_ROBIN ? ~last_q : 1'b0;
            !r0_valid && r1_valid: gnt = 1'b1;
            default:               gnt = 1'b0;
        endcase
    end

    // No accept while reset is asserted, so a requester never sees a
    // handshake that the state machine is about to throw away.
    assign idle     = (state == IDLE);
    assign r0_ready = idle & ~rst & r0_valid & ~gnt;
    assign r1_ready = idle & ~rst & r1_valid & gnt;
    assign accept   = r0_ready | r1_ready;

    assign r0_rsp_valid = (state == RESP) & ~owner_q;
    assign r1_rsp_valid = (state == RESP) & owner_q;
    assign rsp_fire     = (r0_rsp_valid & r0_rsp_ready)
                        | (r1_rsp_valid & r1_rsp_ready);

    assign r0_result = res_q;
    assign r1_result = res_q;
    assign r0_flags  = flg_q;
    assign r1_flags  = flg_q;

    assign alu_op    = op_q;
    assign alu_src_a = a_q;
    assign alu_src_b = b_q;
    assign busy      = ~idle;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            flg_q   <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_q    <= gnt ? r1_op : r0_op;
                        a_q     <= gnt ? r1_a : r0_a;
                        b_q     <= gnt ? r1_b : r0_b;
                        owner_q <= gnt;
                        last_q  <= gnt;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    res_q <= alu_result;
                    flg_q <= {alu_carry, alu_negative,
                              alu_overflow, alu_zero};
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_fire) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a behavioural ALU and transaction-level
// expectations; one round-robin and one fixed-priority instance.
module tb_alu_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         r0_valid, r1_valid;
    logic         r0_rsp_ready, r1_rsp_ready;
    logic [3:0]   r0_op, r1_op;
    logic [W-1:0] r0_a, r0_b, r1_a, r1_b;

    logic         r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid;
    logic [W-1:0] r0_result, r1_result;
    logic [3:0]   r0_flags, r1_flags;
    logic [3:0]   alu_op;
    logic [W-1:0] alu_src_a, alu_src_b, alu_result;
    logic         alu_zero, alu_overflow, alu_negative, alu_carry, busy;

    logic         f_r0_ready, f_r1_ready, f_r0_rsp_valid, f_r1_rsp_valid;
    logic [W-1:0] f_r0_result, f_r1_result;
    logic [3:0]   f_r0_flags, f_r1_flags;
    logic [3:0]   f_alu_op;
    logic [W-1:0] f_alu_src_a, f_alu_src_b, f_alu_result;
    logic         f_alu_zero, f_alu_overflow, f_alu_negative, f_alu_carry;
    logic         f_busy;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    // Reference ALU: returns {carry,negative,overflow,zero,result}
    function automatic logic [W+3:0] alu_f(input logic [3:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c, v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[W-1:0];
                c = s[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            4'd1: begin
                r = a - b;
                c = (a >= b);
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            default: r = a;
        endcase
        return {c, r[W-1], v, (r == '0), r};
    endfunction

    assign {alu_carry, alu_negative, alu_overflow, alu_zero, alu_result} =
        alu_f(alu_op, alu_src_a, alu_src_b);
    assign {f_alu_carry, f_alu_negative, f_alu_overflow, f_alu_zero,
            f_alu_result} = alu_f(f_alu_op, f_alu_src_a, f_alu_src_b);

    alu_arbiter #(.WIDTH(W), .ROUND_ROBIN(1'b1)) u_rr (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op),
        .r0_a(r0_a), .r0_b(r0_b), .r0_rsp_valid(r0_rsp_valid),
        .r0_rsp_ready(r0_rsp_ready), .r0_result(r0_result),
        .r0_flags(r0_flags),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op),
        .r1_a(r1_a), .r1_b(r1_b), .r1_rsp_valid(r1_rsp_valid),
        .r1_rsp_ready(r1_rsp_ready), .r1_result(r1_result),
        .r1_flags(r1_flags),
        .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .alu_negative(alu_negative),
        .alu_carry(alu_carry), .busy(busy)
    );

    alu_arbiter #(.WIDTH(W), .ROUND_ROBIN(1'b0)) u_fp (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(f_r0_ready), .r0_op(r0_op),
        .r0_a(r0_a), .r0_b(r0_b), .r0_rsp_valid(f_r0_rsp_valid),
        .r0_rsp_ready(r0_rsp_ready), .r0_result(f_r0_result),
        .r0_flags(f_r0_flags),
        .r1_valid(r1_valid), .r1_ready(f_r1_ready), .r1_op(r1_op),
        .r1_a(r1_a), .r1_b(r1_b), .r1_rsp_valid(f_r1_rsp_valid),
        .r1_rsp_ready(r1_rsp_ready), .r1_result(f_r1_result),
        .r1_flags(f_r1_flags),
        .alu_op(f_alu_op), .alu_src_a(f_alu_src_a),
        .alu_src_b(f_alu_src_b), .alu_result(f_alu_result),
        .alu_zero(f_alu_zero), .alu_overflow(f_alu_overflow),
        .alu_negative(f_alu_negative), .alu_carry(f_alu_carry),
        .busy(f_busy)
    );

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        r0_valid = 0; r1_valid = 0;
        r0_rsp_ready = 0; r1_rsp_ready = 0;
        r0_op = '0; r1_op = '0;
        r0_a = '0; r0_b = '0; r1_a = '0; r1_b = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        nxt();
        nxt();
        rst = 0;
    endtask

    task automatic rand_r0();
        r0_op = 4'($urandom_range(0, 4));
        r0_a = $urandom;
        r0_b = $urandom;
    endtask

    task automatic rand_r1();
        r1_op = 4'($urandom_range(0, 4));
        r1_a = $urandom;
        r1_b = $urandom;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        nxt();
        nxt();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL reset_busy got %b want 0", busy);
        end
        checks++;
        if ({r1_rsp_valid, r0_rsp_valid} !== 2'b00) begin
            fails++;
            $display("FAIL reset_rspv got %b%b want 00",
                     r1_rsp_valid, r0_rsp_valid);
        end
        checks++;
        if (r0_result !== '0 || r0_flags !== 4'h0) begin
            fails++;
            $display("FAIL reset_res got %h/%h want 0/0", r0_result, r0_flags);
        end
        checks++;
        if (alu_op !== 4'h0 || alu_src_a !== '0 || alu_src_b !== '0) begin
            fails++;
            $display("FAIL reset_alu got %h %h %h want 0 0 0",
                     alu_op, alu_src_a, alu_src_b);
        end
        checks++;
        if (f_busy !== 1'b0 || f_r1_result !== '0 || f_r1_flags !== 4'h0) begin
            fails++;
            $display("FAIL reset_fp got %b %h %h want 0 0 0",
                     f_busy, f_r1_result, f_r1_flags);
        end
        nxt();
        rst = 0;
    endtask

    task automatic test_single();
        do_reset();
        r0_op = 4'd0; r0_a = 5; r0_b = 7;
        r0_valid = 1; r0_rsp_ready = 1;
        @(negedge clk);
        checks++;
        if ({r1_ready, r0_ready} !== 2'b01) begin
            fails++;
            $display("FAIL single_ready got %b%b want 01", r1_ready, r0_ready);
        end
        nxt();
        r0_valid = 0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || r0_rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_exec got busy=%b rspv=%b want 1 0",
                     busy, r0_rsp_valid);
        end
        nxt();
        @(negedge clk);
        checks++;
        if ({r1_rsp_valid, r0_rsp_valid} !== 2'b01) begin
            fails++;
            $display("FAIL single_rspv got %b%b want 01",
                     r1_rsp_valid, r0_rsp_valid);
        end
        checks++;
        if (r0_result !== 32'd12 || r0_flags !== 4'b0000) begin
            fails++;
            $display("FAIL single_res got %0d/%b want 12/0000",
                     r0_result, r0_flags);
        end
        nxt();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL single_idle got busy=%b want 0", busy);
        end
        nxt();
    endtask

    task automatic test_round_robin();
        logic [W+3:0] exp;
        logic [1:0]   oh;
        logic [W-1:0] got_r;
        logic [3:0]   got_f;
        do_reset();
        rand_r0();
        rand_r1();
        r0_valid = 1; r1_valid = 1;
        r0_rsp_ready = 1; r1_rsp_ready = 1;
        for (int k = 0; k < 6; k++) begin
            oh = (k % 2 == 1) ? 2'b10 : 2'b01;
            exp = (k % 2 == 1) ? alu_f(r1_op, r1_a, r1_b)
                               : alu_f(r0_op, r0_a, r0_b);
            @(negedge clk);
            checks++;
            if ({r1_ready, r0_ready} !== oh) begin
                fails++;
                $display("FAIL rr_grant%0d got %b%b want %b",
                         k, r1_ready, r0_ready, oh);
            end
            nxt();
            if (k % 2 == 1) rand_r1();
            else rand_r0();
            @(negedge clk);
            checks++;
            if ({r1_ready, r0_ready} !== 2'b00) begin
                fails++;
                $display("FAIL rr_busy_ready%0d got %b%b want 00",
                         k, r1_ready, r0_ready);
            end
            nxt();
            @(negedge clk);
            checks++;
            if ({r1_rsp_valid, r0_rsp_valid} !== oh) begin
                fails++;
                $display("FAIL rr_route%0d got %b%b want %b",
                         k, r1_rsp_valid, r0_rsp_valid, oh);
            end
            got_r = oh[1] ? r1_result : r0_result;
            got_f = oh[1] ? r1_flags : r0_flags;
            checks++;
            if (got_r !== exp[W-1:0] || got_f !== exp[W+3:W]) begin
                fails++;
                $display("FAIL rr_result%0d got %h/%b want %h/%b",
                         k, got_r, got_f, exp[W-1:0], exp[W+3:W]);
            end
            nxt();
        end
        clear_inputs();
    endtask

    task automatic test_fixed();
        logic [W+3:0] exp;
        exp = '0;
        do_reset();
        rand_r0();
        rand_r1();
        r0_valid = 1; r1_valid = 1;
        r0_rsp_ready = 1; r1_rsp_ready = 1;
        for (int c = 0; c < 21; c++) begin
            @(negedge clk);
            checks++;
            if (f_r1_ready !== 1'b0) begin
                fails++; $display("FAIL fp_r1_ready c%0d got 1 want 0", c);
            end
            checks++;
            if (f_r0_ready !== (c % 3 == 0)) begin
                fails++;
                $display("FAIL fp_r0_ready c%0d got %b want %b",
                         c, f_r0_ready, (c % 3 == 0));
            end
            if (c % 3 == 0) exp = alu_f(r0_op, r0_a, r0_b);
            if (c % 3 == 2) begin
                checks++;
                if (f_r0_rsp_valid !== 1'b1 || f_r1_rsp_valid !== 1'b0 ||
                    f_r0_result !== exp[W-1:0] ||
                    f_r0_flags !== exp[W+3:W]) begin
                    fails++;
                    $display("FAIL fp_rsp c%0d got %b%b %h/%b want 01 %h/%b",
                             c, f_r1_rsp_valid, f_r0_rsp_valid, f_r0_result,
                             f_r0_flags, exp[W-1:0], exp[W+3:W]);
                end
            end
            nxt();
            if (c % 3 == 0) rand_r0();
        end
        clear_inputs();
    endtask

    task automatic test_hold();
        do_reset();
        r1_op = 4'd1; r1_a = 3; r1_b = 3;
        r1_valid = 1; r1_rsp_ready = 0;
        @(negedge clk);
        checks++;
        if (r1_ready !== 1'b1) begin
            fails++; $display("FAIL hold_accept got %b want 1", r1_ready);
        end
        nxt();
        r1_valid = 0;
        rand_r0();
        r0_valid = 1;
        @(negedge clk);
        checks++;
        if (r0_ready !== 1'b0) begin
            fails++; $display("FAIL hold_exec_r0_ready got 1 want 0");
        end
        nxt();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (r1_rsp_valid !== 1'b1 || r0_rsp_valid !== 1'b0) begin
                fails++;
                $display("FAIL hold_rspv%0d got %b%b want 10",
                         i, r1_rsp_valid, r0_rsp_valid);
            end
            checks++;
            if (r1_result !== '0 || r1_flags !== 4'b1001) begin
                fails++;
                $display("FAIL hold_res%0d got %h/%b want 0/1001",
                         i, r1_result, r1_flags);
            end
            checks++;
            if (r0_ready !== 1'b0) begin
                fails++; $display("FAIL hold_r0_ready%0d got 1 want 0", i);
            end
            nxt();
        end
        r1_rsp_ready = 1;
        @(negedge clk);
        checks++;
        if (r1_rsp_valid !== 1'b1 || r0_ready !== 1'b0) begin
            fails++;
            $display("FAIL hold_hs got rspv=%b r0_ready=%b want 1 0",
                     r1_rsp_valid, r0_ready);
        end
        nxt();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || r1_rsp_valid !== 1'b0 || r0_ready !== 1'b1) begin
            fails++;
            $display("FAIL hold_after got busy=%b rspv=%b r0_ready=%b want 0 0 1",
                     busy, r1_rsp_valid, r0_ready);
        end
        nxt();
        clear_inputs();
    endtask

    task automatic test_carry();
        do_reset();
        r0_op = 4'd0; r0_a = 32'hFFFF_FFFF; r0_b = 32'd1;
        r0_valid = 1; r0_rsp_ready = 0;
        @(negedge clk);
        checks++;
        if (r0_ready !== 1'b1) begin
            fails++; $display("FAIL carry_accept got %b want 1", r0_ready);
        end
        nxt();
        r0_valid = 0;
        r0_op = 4'd2; r0_a = $urandom; r0_b = $urandom;
        @(negedge clk);
        checks++;
        if (alu_src_a !== 32'hFFFF_FFFF || alu_src_b !== 32'd1 ||
            alu_op !== 4'd0) begin
            fails++;
            $display("FAIL carry_alu got %h %h %h want 0 ffffffff 1",
                     alu_op, alu_src_a, alu_src_b);
        end
        nxt();
        for (int i = 0; i < 2; i++) begin
            r0_a = $urandom;
            @(negedge clk);
            checks++;
            if (r0_rsp_valid !== 1'b1 || r0_result !== '0 ||
                r0_flags !== 4'b1001) begin
                fails++;
                $display("FAIL carry_rsp%0d got %b %h/%b want 1 0/1001",
                         i, r0_rsp_valid, r0_result, r0_flags);
            end
            nxt();
        end
        r0_rsp_ready = 1;
        nxt();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || r0_rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL carry_done got busy=%b rspv=%b want 0 0",
                     busy, r0_rsp_valid);
        end
        nxt();
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        logic [W+3:0] exp;
        do_reset();
        rand_r1();
        exp = alu_f(r1_op, r1_a, r1_b);
        r1_valid = 1; r1_rsp_ready = 0;
        @(negedge clk);
        checks++;
        if (r1_ready !== 1'b1) begin
            fails++; $display("FAIL mid_accept got %b want 1", r1_ready);
        end
        nxt();
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            fails++; $display("FAIL mid_exec got busy=%b want 1", busy);
        end
        rst = 1;
        nxt();
        rst = 0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || r1_rsp_valid !== 1'b0 || r1_ready !== 1'b1) begin
            fails++;
            $display("FAIL mid_rst_exec got busy=%b rspv=%b rdy=%b want 0 0 1",
                     busy, r1_rsp_valid, r1_ready);
        end
        nxt();
        nxt();
        @(negedge clk);
        checks++;
        if (r1_rsp_valid !== 1'b1 || r1_result !== exp[W-1:0]) begin
            fails++;
            $display("FAIL mid_resp got %b %h want 1 %h",
                     r1_rsp_valid, r1_result, exp[W-1:0]);
        end
        rst = 1;
        nxt();
        rst = 0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || r1_rsp_valid !== 1'b0 || r1_ready !== 1'b1) begin
            fails++;
            $display("FAIL mid_rst_resp got busy=%b rspv=%b rdy=%b want 0 0 1",
                     busy, r1_rsp_valid, r1_ready);
        end
        nxt();
        r1_valid = 0;
        r1_rsp_ready = 1;
        nxt();
        @(negedge clk);
        checks++;
        if (r1_rsp_valid !== 1'b1 || r1_result !== exp[W-1:0] ||
            r1_flags !== exp[W+3:W]) begin
            fails++;
            $display("FAIL mid_final got %b %h/%b want 1 %h/%b",
                     r1_rsp_valid, r1_result, r1_flags,
                     exp[W-1:0], exp[W+3:W]);
        end
        nxt();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL mid_idle got busy=%b want 0", busy);
        end
        nxt();
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fixed();
        test_hold();
        test_carry();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
